lsu_bus_ctrl: RTL and testbench

Multi-cycle load/store unit between the core datapath and a valid/ready data-memory bus. It takes the ALU-computed address and the store data, sizes and aligns byte/halfword/word accesses, and runs a request/response handshake with the memory. It stalls the core until the access completes and returns sign- or zero-extended load data on `ReadData`. Misaligned accesses and bus timeouts are reported as one-cycle fault pulses instead of being issued to the bus.

---
 rtl/lsu_bus_ctrl_if.sv | 22 ++
 rtl/lsu_bus_ctrl.sv | 165 ++++++++++++++++
 tb/tb_lsu_bus_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_bus_ctrl_if.sv
// Valid/ready data-memory bus between the load/store unit (master) and memory (slave).
// Writes are acknowledged through bus_rvalid, just as reads are.
interface lsu_bus_ctrl_if;
  logic        bus_valid;
  logic        bus_ready;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_wstrb;
  logic        bus_rvalid;
  logic [31:0] bus_rdata;

  modport master (
    output bus_valid, bus_we, bus_addr, bus_wdata, bus_wstrb,
    input  bus_ready, bus_rvalid, bus_rdata
  );

  modport slave (
    input  bus_valid, bus_we, bus_addr, bus_wdata, bus_wstrb,
    output bus_ready, bus_rvalid, bus_rdata
  );
endinterface

// File: rtl/lsu_bus_ctrl.sv
// Multi-cycle load/store unit: sizes and aligns core accesses, runs the memory handshake,
// stalls the core until completion and returns extended load data and fault pulses.
module lsu_bus_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           MemRead,
  input  logic           MemWrite,
  input  logic [2:0]     funct3,
  input  logic [31:0]    ALUResult,
  input  logic [31:0]    WriteData,
  output logic [31:0]    ReadData,
  output logic           Stall,
  output logic           load_misaligned,
  output logic           store_misaligned,
  output logic           bus_err,
  lsu_bus_ctrl_if.master bus
);
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
  state_t state_q, state_d;

  logic [31:0] addr_p0;
  logic [31:0] wdata_p0;
  logic [3:0]  wstrb_p0;
  logic [2:0]  f3_p0;
  logic        we_p0;
  logic        mis_p0;
  logic [15:0] cnt_p1;
  logic [31:0] rdata_p1;
  logic        err_p1;

  logic req;
  logic req_mis;
  logic timeout;

  // funct3[1:0] selects the size: 00 byte, 01 halfword, anything else is a word.
  function automatic logic is_misaligned(input logic [1:0] a, input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 1'b0;
      2'b01:   return a[0];
      default: return (a != 2'b00);
    endcase
  endfunction

  function automatic logic [31:0] format_wdata(input logic [31:0] wd, input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return {4{wd[7:0]}};
      2'b01:   return {2{wd[15:0]}};
      default: return wd;
    endcase
  endfunction

  function automatic logic [3:0] format_wstrb(input logic [1:0] a, input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 4'b0001 << a;
      2'b01:   return 4'b0011 << {a[1], 1'b0};
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] extract_load(input logic [31:0] rd, input logic [1:0] a,
                                               input logic [2:0] f3);
    logic signed [7:0]  b_s;
    logic signed [15:0] h_s;
    b_s = rd[{a, 3'b000} +: 8];
    h_s = a[1] ? rd[31:16] : rd[15:0];
    case (f3[1:0])
      2'b00: begin
        if (f3[2]) return {24'd0, b_s};
        return 32'(b_s);
      end
      2'b01: begin
        if (f3[2]) return {16'd0, h_s};
        return 32'(h_s);
      end
      default: return rd;
    endcase
  endfunction

  assign req     = MemRead | MemWrite;
  assign req_mis = is_misaligned(ALUResult[1:0], funct3);
  assign timeout = (cnt_p1 == TO_LAST);

  always_ff @(posedge clk) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    Stall         = 1'b0;
    bus.bus_valid = 1'b0;
    case (state_q)
      IDLE: begin
        Stall = req;
        if (req) state_d = req_mis ? DONE : REQ;
      end
      REQ: begin
        Stall         = 1'b1;
        bus.bus_valid = 1'b1;
        if (bus.bus_ready) state_d = WAIT;
      end
      WAIT: begin
        Stall = 1'b1;
        if (bus.bus_rvalid || timeout) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // p0: request capture in IDLE; p1: response/timeout capture in REQ/WAIT
  always_ff @(posedge clk) begin
    if (!reset) begin
      addr_p0  <= '0;
      wdata_p0 <= '0;
      wstrb_p0 <= '0;
      f3_p0    <= '0;
      we_p0    <= 1'b0;
      mis_p0   <= 1'b0;
      cnt_p1   <= '0;
      rdata_p1 <= '0;
      err_p1   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (req) begin
          addr_p0  <= ALUResult;
          f3_p0    <= funct3;
          we_p0    <= MemWrite;
          mis_p0   <= req_mis;
          wdata_p0 <= MemWrite ? format_wdata(WriteData, funct3) : '0;
          wstrb_p0 <= MemWrite ? format_wstrb(ALUResult[1:0], funct3) : '0;
          rdata_p1 <= '0;
          err_p1   <= 1'b0;
          cnt_p1   <= '0;
        end
        REQ: if (bus.bus_ready) cnt_p1 <= '0;
        WAIT: begin
          if (bus.bus_rvalid) begin
            if (!we_p0) rdata_p1 <= extract_load(bus.bus_rdata, addr_p0[1:0], f3_p0);
          end else if (timeout) begin
            err_p1 <= 1'b1;
          end else begin
            cnt_p1 <= cnt_p1 + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // p2: outputs, qualified by DONE so results and faults are single-cycle
  assign bus.bus_we    = we_p0;
  assign bus.bus_addr  = {addr_p0[31:2], 2'b00};
  assign bus.bus_wdata = wdata_p0;
  assign bus.bus_wstrb = wstrb_p0;

  assign ReadData         = (state_q == DONE) ? rdata_p1 : '0;
  assign load_misaligned  = (state_q == DONE) && mis_p0 && !we_p0;
  assign store_misaligned = (state_q == DONE) && mis_p0 && we_p0;
  assign bus_err          = (state_q == DONE) && err_p1;
endmodule

// File: tb/tb_lsu_bus_ctrl.sv
// Scoreboard bench for lsu_bus_ctrl: randomized loads/stores against a reference model,
// with a responsive memory that injects ready/rvalid delays, timeouts and stray responses.
module tb_lsu_bus_ctrl;
  localparam int T = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        MemRead = 1'b0;
  logic        MemWrite = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] ALUResult = 32'd0;
  logic [31:0] WriteData = 32'd0;
  logic [31:0] ReadData;
  logic        Stall;
  logic        load_misaligned;
  logic        store_misaligned;
  logic        bus_err;

  lsu_bus_ctrl_if bus_if ();

  lsu_bus_ctrl #(.TIMEOUT_CYCLES(T)) dut (
    .clk              (clk),
    .reset            (reset),
    .MemRead          (MemRead),
    .MemWrite         (MemWrite),
    .funct3           (funct3),
    .ALUResult        (ALUResult),
    .WriteData        (WriteData),
    .ReadData         (ReadData),
    .Stall            (Stall),
    .load_misaligned  (load_misaligned),
    .store_misaligned (store_misaligned),
    .bus_err          (bus_err),
    .bus              (bus_if.master)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        lmis;
    logic        smis;
    logic        err;
    int          stall;
  } res_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        we;
  } req_t;

  res_t res_q[$];
  req_t req_q[$];
  res_t exp_r;
  req_t exp_b;
  int   checks = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: byte arithmetic on size/offset, independent of any state machine.
  function automatic void model(input bit rd, input bit wr, input logic [2:0] f3,
                                input logic [31:0] addr, input logic [31:0] wd,
                                input logic [31:0] rdata, input int rdy, input int rvl,
                                input bit never, output res_t r, output req_t b,
                                output bit mis);
    int          size;
    int          sh;
    bit          sgn;
    logic [31:0] mask;
    logic [31:0] v;
    size = (f3 == 3'd0 || f3 == 3'd4) ? 1 : (f3 == 3'd1 || f3 == 3'd5) ? 2 : 4;
    sgn  = (f3 == 3'd0 || f3 == 3'd1);
    mis  = (addr % size) != 0;
    sh   = 8 * (addr % 4);
    mask = (size == 4) ? 32'hFFFF_FFFF : (32'd1 << (8 * size)) - 32'd1;
    v    = (rdata >> sh) & mask;
    if (sgn && size < 4 && v[8*size-1]) v = v | ~mask;
    b.addr  = addr & ~32'd3;
    b.we    = wr;
    b.wdata = (size == 1) ? {24'd0, wd[7:0]} * 32'h0101_0101 :
              (size == 2) ? {16'd0, wd[15:0]} * 32'h0001_0001 : wd;
    b.wstrb = wr ? 4'(((1 << size) - 1) << (addr % 4)) : 4'd0;
    r.rdata = (wr || mis || never) ? 32'd0 : v;
    r.lmis  = mis && !wr;
    r.smis  = mis && wr;
    r.err   = !mis && never;
    r.stall = mis ? 1 : 1 + (rdy + 1) + (never ? T : rvl + 1);
    if (rd) begin end
  endfunction

  // Memory responder
  int          cfg_rdy = 0;
  int          cfg_rvl = 0;
  bit          cfg_never = 1'b0;
  logic [31:0] cfg_rdata = 32'd0;
  int          ph = 0;
  int          k = 0;

  always @(negedge clk) begin
    bus_if.bus_ready  = 1'b0;
    bus_if.bus_rvalid = 1'b0;
    bus_if.bus_rdata  = $urandom;
    if (ph != 0 && !Stall) ph = 0;
    if (ph == 0 && bus_if.bus_valid) begin
      ph = 1;
      k  = 0;
    end
    if (ph == 0) begin
      bus_if.bus_rvalid = 1'($urandom_range(0, 1));
    end else if (ph == 1) begin
      if (k >= cfg_rdy) begin
        bus_if.bus_ready = 1'b1;
        ph = 2;
        k  = 0;
      end else begin
        k++;
        bus_if.bus_rvalid = 1'($urandom_range(0, 1));
      end
    end else begin
      if (!cfg_never && k >= cfg_rvl) begin
        bus_if.bus_rvalid = 1'b1;
        bus_if.bus_rdata  = cfg_rdata;
        ph = 0;
      end else begin
        k++;
      end
    end
  end

  // Monitor
  bit rst_edge = 1'b0;
  bit prev_stall = 1'b0;
  bit prev_valid = 1'b0;
  int nstall = 0;

  always @(posedge clk) rst_edge = !reset;

  always @(negedge clk) begin
    if (rst_edge) begin
      chk("rst_stall", 32'(Stall), 32'(MemRead | MemWrite));
      chk("rst_valid", 32'(bus_if.bus_valid), 32'd0);
      chk("rst_rdata", ReadData, 32'd0);
      chk("rst_flags", 32'({load_misaligned, store_misaligned, bus_err}), 32'd0);
      chk("rst_we_strb", 32'({bus_if.bus_we, bus_if.bus_wstrb}), 32'd0);
      chk("rst_addr", bus_if.bus_addr, 32'd0);
      prev_stall = Stall;
      prev_valid = bus_if.bus_valid;
      nstall     = Stall ? 1 : 0;
    end else begin
      if (Stall) nstall++;
      if (prev_stall && !Stall) begin
        if (res_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL done_unexpected: completion with empty scoreboard (t=%0t)", $time);
        end else begin
          exp_r = res_q.pop_front();
          chk("rdata", ReadData, exp_r.rdata);
          chk("load_mis", 32'(load_misaligned), 32'(exp_r.lmis));
          chk("store_mis", 32'(store_misaligned), 32'(exp_r.smis));
          chk("bus_err", 32'(bus_err), 32'(exp_r.err));
          chk("stall_cycles", 32'(nstall), 32'(exp_r.stall));
        end
        nstall = 0;
      end else begin
        chk("quiet_rdata", ReadData, 32'd0);
        chk("quiet_flags", 32'({load_misaligned, store_misaligned, bus_err}), 32'd0);
      end
      if (bus_if.bus_valid && !prev_valid) begin
        if (req_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL req_unexpected: bus_valid with empty scoreboard (t=%0t)", $time);
        end else begin
          exp_b = req_q.pop_front();
          chk("bus_addr", bus_if.bus_addr, exp_b.addr);
          chk("bus_we", 32'(bus_if.bus_we), 32'(exp_b.we));
          chk("bus_wstrb", 32'(bus_if.bus_wstrb), 32'(exp_b.wstrb));
          if (exp_b.we) chk("bus_wdata", bus_if.bus_wdata, exp_b.wdata);
        end
      end else if (bus_if.bus_valid) begin
        chk("hold_addr", bus_if.bus_addr, exp_b.addr);
        chk("hold_wstrb", 32'(bus_if.bus_wstrb), 32'(exp_b.wstrb));
        if (exp_b.we) chk("hold_wdata", bus_if.bus_wdata, exp_b.wdata);
      end
      prev_stall = Stall;
      prev_valid = bus_if.bus_valid;
    end
  end

  // Drive one instruction and hold it until the DONE cycle (or abort it with reset in WAIT).
  task automatic issue(input bit rd, input bit wr, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [31:0] rdata, input int rdy,
                       input int rvl, input bit never, input bit abort);
    res_t r;
    req_t b;
    bit   mis;
    int   n;
    model(rd, wr, f3, addr, wd, rdata, rdy, rvl, never, r, b, mis);
    if (!abort) res_q.push_back(r);
    if (!mis) req_q.push_back(b);
    cfg_rdy   = rdy;
    cfg_rvl   = rvl;
    cfg_never = never;
    cfg_rdata = rdata;
    MemRead   = rd;
    MemWrite  = wr;
    funct3    = f3;
    ALUResult = addr;
    WriteData = wd;
    if (abort) begin
      repeat (rdy + 3) @(posedge clk);
      #1;
      reset    = 1'b0;
      MemRead  = 1'b0;
      MemWrite = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b1;
    end else begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (Stall && n < 300);
      if (Stall) begin
        checks++;
        failures++;
        $display("FAIL complete_bound: Stall still 1 after %0d cycles", n);
      end
      @(posedge clk);
      #1;
      MemRead  = 1'b0;
      MemWrite = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  f3;
    logic [31:0] addr;
    int          op;
    int          gap;
    bus_if.bus_ready  = 1'b0;
    bus_if.bus_rvalid = 1'b0;
    bus_if.bus_rdata  = 32'd0;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;

    issue(1, 0, 3'b010, 32'h0000_0100, 32'd0, 32'hDEAD_BEEF, 0, 0, 0, 0);
    issue(1, 0, 3'b000, 32'h0000_0103, 32'd0, 32'h80FF_1234, 0, 0, 0, 0);
    issue(1, 0, 3'b100, 32'h0000_0103, 32'd0, 32'h80FF_1234, 0, 0, 0, 0);
    issue(1, 0, 3'b101, 32'h0000_0102, 32'd0, 32'h80FF_1234, 0, 0, 0, 0);
    issue(0, 1, 3'b000, 32'h0000_0206, 32'h0000_00A5, 32'd0, 0, 0, 0, 0);
    issue(1, 0, 3'b001, 32'h0000_0101, 32'd0, 32'd0, 0, 0, 0, 0);
    issue(0, 1, 3'b010, 32'h0000_0102, 32'h1234_5678, 32'd0, 0, 0, 0, 0);
    issue(1, 0, 3'b010, 32'h0000_0300, 32'd0, 32'h1234_5678, 5, 3, 0, 0);
    issue(1, 0, 3'b010, 32'h0000_0400, 32'd0, 32'hCAFE_F00D, 0, 0, 1, 0);
    issue(1, 1, 3'b001, 32'h0000_0502, 32'hBEEF_7E57, 32'h5555_AAAA, 1, 1, 0, 0);

    for (int i = 0; i < 80; i++) begin
      f3   = 3'($urandom_range(0, 7));
      addr = $urandom;
      if ($urandom_range(0, 1) == 1) addr = addr & ~32'd3;
      op = $urandom_range(0, 3);
      issue(op != 1, op == 1 || op == 2, f3, addr, $urandom, $urandom,
            $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 9) == 0, 0);
      gap = $urandom_range(0, 2);
      repeat (gap) begin
        @(posedge clk);
        #1;
      end
    end

    issue(1, 0, 3'b010, 32'h0000_0600, 32'd0, 32'h0BAD_0BAD, 2, 0, 1, 1);
    repeat (6) begin
      @(posedge clk);
      #1;
    end
    issue(1, 0, 3'b010, 32'h0000_0700, 32'd0, 32'h7777_1111, 0, 0, 0, 0);
    repeat (4) begin
      @(posedge clk);
      #1;
    end

    chk("res_q_empty", 32'(res_q.size()), 32'd0);
    chk("req_q_empty", 32'(req_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
